ram_arbiter: RTL
================

# ram_arbiter

Owns the single RAM port and sequences it through boot and run. After reset it gives the RAM exclusively to the hex loader. Once the loader signals done, it drains in-flight operations, releases the CPU, and from then on round-robin arbitrates the RAM between the CPU and the debug monitor. It sits between the requesters and the RAM. It also routes load data back to whichever requester issued the load.

## Interface
- `LOAD_LAT`, default 2: cycles from `ram_op` issue (registered output) to valid `ram_rdata`; ≥1.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset is synchronous, active-high.
- `ld_op`, `ld_addr`, `ld_size`, `ld_data` in: loader request, `pkg_ram` op type / `RAM_ADDRW` / size type / `RAM_QUAD`. A loader request is a one-cycle pulse, store only.
- `ld_done` in 1: loader finished; level, sticky until reset.
- `cpu_op`, `cpu_addr`, `cpu_size`, `cpu_data` in: CPU request, same widths. Any op ≠ `RAM_NOP` is a request.
- `cpu_gnt` out 1: request accepted this cycle.
- `cpu_rvalid` out 1: load data valid.
- `cpu_rdata` out `RAM_QUAD`: load data.
- `mon_op`, `mon_addr`, `mon_size`, `mon_data`, `mon_gnt`, `mon_rvalid`, `mon_rdata`: monitor port, identical to the CPU port.
- `run` out 1: high while in RUN (CPU released).
- `ram_op`, `ram_addr`, `ram_size`, `ram_data` out: registered RAM request.
- `ram_rdata` in `RAM_QUAD`: RAM load data.

## Operation
- FSM states:
  - **LOAD**: the loader owns the RAM.
    - Each cycle with `ld_op != RAM_NOP`, forward the loader fields to `ram_*` on the next edge.
    - CPU and monitor requests are not granted; both `*_gnt` are 0.
    - `ld_done`=1 → DRAIN. A loader op in the same cycle as `ld_done` is still forwarded.
  - **DRAIN**: `ram_op`=NOP. A counter waits `LOAD_LAT`+1 cycles → RUN. Loader ops are ignored.
  - **RUN**: `run`=1, permanent until `rst`. Loader inputs are ignored.
- Arbitration in RUN:
  - A single requester is granted immediately.
  - On simultaneous requests, grant the one not granted most recently. The `last` pointer resets to MON, so the CPU wins the first tie.
  - The granted port's fields go to `ram_*` on the next edge. With no grant, `ram_op`=NOP.
- Requester rule: hold op/addr/size/data stable until `*_gnt` is sampled high. A new request may be presented in the cycle after the grant, so one grant per cycle is possible (back-to-back).
- Response routing:
  - Each issued op pushes an owner tag into a `LOAD_LAT`-deep shift register: NONE, CPU or MON. Stores and NOPs push NONE.
  - At the tap, a CPU/MON tag asserts that port's `rvalid` for one cycle with `rdata` = `ram_rdata`.
  - `*_rdata` is don't-care while `rvalid`=0; drive 0.
- Widths: `ram_*` are pass-through with no arithmetic. The DRAIN counter is `$clog2(LOAD_LAT+2)` bits.

## Timing
- Reset values:
  - State LOAD, `run`=0, `ram_op`=`RAM_NOP`.
  - `ram_addr`/`ram_data`=0, `ram_size`=`RAM_BYTE`.
  - All `gnt`/`rvalid`=0, tag pipe all NONE, `last`=MON.
- Grant is combinational in the request cycle T. `ram_op` is valid at T+1. The load response, `*_rvalid`, arrives at T+1+`LOAD_LAT`.
- Loader op at cycle T appears on `ram_op` at T+1. There is no backpressure toward the loader.
- `ld_done` rising at T:
  - DRAIN during T+1 … T+`LOAD_LAT`+1.
  - `run`=1 and first possible grant at T+`LOAD_LAT`+2.
- `rst` mid-operation:
  - The next edge clears everything to reset values.
  - Pending responses are dropped; no `rvalid` is emitted after reset.
- `ld_done` already high out of reset: one LOAD cycle, then DRAIN.

## Structure
- `pkg_ram` gains:
  - `arb_state_t` enum {ARB_LOAD, ARB_DRAIN, ARB_RUN};
  - `arb_owner_t` enum {OWN_NONE, OWN_CPU, OWN_MON}.
- One sub-module, `ram_rsp_tag`: parameter `LOAD_LAT`, push `arb_owner_t`, tap output. It is a shift register cleared by `rst`.
- FSM, arbiter and request mux stay in `ram_arbiter`.

## Test plan
- **Boot load**: loader stores 0xAB@0, 0xCD@1 while `cpu_op`=LOAD@0 is held → `ram_op` shows both stores at T+1, `cpu_gnt` stays 0. With `ld_done` at T, the CPU is granted at T+`LOAD_LAT`+2 and `cpu_rvalid`, `cpu_rdata`=0xAB arrive `LOAD_LAT`+1 cycles later.
- **Tie round-robin in RUN**: CPU and monitor both hold loads for 4 cycles → grants go CPU, MON, CPU, MON. Each `rvalid` goes to the correct port with its own address data.
- **Back-to-back**: CPU loads @0..3 on consecutive cycles → 4 consecutive `ram_op`s and 4 consecutive `cpu_rvalid` with matching data; `mon_rvalid` stays 0.
- **Store without response**: monitor stores 0x5A@8 → `ram_op`=STORE at T+1, no `mon_rvalid`. A later CPU load @8 returns 0x5A.
- **Reset mid-flight**: CPU load granted, then `rst` pulsed before the response → no `cpu_rvalid`, `run`=0, state LOAD, `ram_op`=NOP.
- **Loader ignored after done**: loader store @0x10 pulsed during DRAIN/RUN → no `ram_op` issued.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared RAM port types plus the boot/run arbiter state and response-owner encodings.
package pkg_ram;
    localparam int RAM_ADDRW = 16;
    localparam int RAM_QUADW = 64;

    typedef logic [RAM_QUADW-1:0] ram_quad_t;

    typedef enum logic [1:0] {RAM_NOP, RAM_LOAD, RAM_STORE} ram_op_t;
    typedef enum logic [1:0] {RAM_BYTE, RAM_HALF, RAM_WORD, RAM_QUAD} ram_size_t;

    typedef struct packed {
        ram_op_t                op;
        logic [RAM_ADDRW-1:0]   addr;
        ram_size_t              size;
        ram_quad_t              data;
    } ram_req_t;

    typedef enum logic [1:0] {ARB_LOAD, ARB_DRAIN, ARB_RUN} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_MON} arb_owner_t;
endpackage

// File: rtl/ram_arbiter_rsp_tag.sv
// Owner-tag delay line: the tag pushed alongside an issued RAM op reaches the tap
// exactly when that op's load data appears on ram_rdata.
module ram_rsp_tag
    import pkg_ram::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  arb_owner_t push,
    output arb_owner_t tap
);
    arb_owner_t pipe [LOAD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LOAD_LAT; i++) pipe[i] <= OWN_NONE;
        end else begin
            pipe[0] <= push;
            for (int i = 1; i < LOAD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tap = pipe[LOAD_LAT-1];
endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM owner: loader-only boot, a drain gap, then CPU/monitor round-robin
// with load responses routed back to the issuing port.
module ram_arbiter
    import pkg_ram::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  ram_op_t              ld_op,
    input  logic [RAM_ADDRW-1:0] ld_addr,
    input  ram_size_t            ld_size,
    input  ram_quad_t            ld_data,
    input  logic                 ld_done,
    input  ram_op_t              cpu_op,
    input  logic [RAM_ADDRW-1:0] cpu_addr,
    input  ram_size_t            cpu_size,
    input  ram_quad_t            cpu_data,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output ram_quad_t            cpu_rdata,
    input  ram_op_t              mon_op,
    input  logic [RAM_ADDRW-1:0] mon_addr,
    input  ram_size_t            mon_size,
    input  ram_quad_t            mon_data,
    output logic                 mon_gnt,
    output logic                 mon_rvalid,
    output ram_quad_t            mon_rdata,
    output logic                 run,
    output ram_op_t              ram_op,
    output logic [RAM_ADDRW-1:0] ram_addr,
    output ram_size_t            ram_size,
    output ram_quad_t            ram_data,
    input  ram_quad_t            ram_rdata
);
    localparam int CNTW = $clog2(LOAD_LAT + 2);

    arb_state_t      state, state_nxt;
    logic [CNTW-1:0] drain_cnt;
    arb_owner_t      last, ram_own, tap;
    logic            cpu_req, mon_req;
    ram_req_t        sel;
    arb_owner_t      sel_own;

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_LOAD:  if (ld_done) state_nxt = ARB_DRAIN;
            ARB_DRAIN: if (drain_cnt == CNTW'(LOAD_LAT)) state_nxt = ARB_RUN;
            ARB_RUN:   state_nxt = ARB_RUN;
            default:   state_nxt = ARB_LOAD;
        endcase
    end

    // Counts 0..LOAD_LAT inside DRAIN so every boot-time load has retired.
    always_ff @(posedge clk) begin
        if (rst || state != ARB_DRAIN) drain_cnt <= '0;
        else                           drain_cnt <= drain_cnt + CNTW'(1);
    end

    assign run     = (state == ARB_RUN);
    assign cpu_req = run && (cpu_op != RAM_NOP);
    assign mon_req = run && (mon_op != RAM_NOP);
    assign cpu_gnt = cpu_req && (!mon_req || last != OWN_CPU);
    assign mon_gnt = mon_req && !cpu_gnt;

    always_comb begin
        sel     = '{op: RAM_NOP, addr: ram_addr, size: ram_size, data: ram_data};
        sel_own = OWN_NONE;
        if (state == ARB_LOAD && ld_op != RAM_NOP) begin
            sel = '{op: ld_op, addr: ld_addr, size: ld_size, data: ld_data};
        end else if (cpu_gnt) begin
            sel     = '{op: cpu_op, addr: cpu_addr, size: cpu_size, data: cpu_data};
            sel_own = (cpu_op == RAM_LOAD) ? OWN_CPU : OWN_NONE;
        end else if (mon_gnt) begin
            sel     = '{op: mon_op, addr: mon_addr, size: mon_size, data: mon_data};
            sel_own = (mon_op == RAM_LOAD) ? OWN_MON : OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_op   <= RAM_NOP;
            ram_addr <= '0;
            ram_size <= RAM_BYTE;
            ram_data <= '0;
            ram_own  <= OWN_NONE;
            last     <= OWN_MON;
        end else begin
            ram_op   <= sel.op;
            ram_addr <= sel.addr;
            ram_size <= sel.size;
            ram_data <= sel.data;
            ram_own  <= sel_own;
            if (cpu_gnt)      last <= OWN_CPU;
            else if (mon_gnt) last <= OWN_MON;
        end
    end

    // The owner is pushed as its op leaves ram_op, so the tag lines up with ram_rdata.
    ram_rsp_tag #(.LOAD_LAT(LOAD_LAT)) u_rsp_tag (
        .clk  (clk),
        .rst  (rst),
        .push (ram_own),
        .tap  (tap)
    );

    assign cpu_rvalid = (tap == OWN_CPU);
    assign mon_rvalid = (tap == OWN_MON);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
    assign mon_rdata  = mon_rvalid ? ram_rdata : '0;
endmodule
